counter_cfg_master: RTL and testbench
=====================================

Name: counter_cfg_master

Overview:
- Bus-master sequencer directly upstream of the up/down counter (PLR/ULR/LLR/CCR register file, 8-bit bus with ncs/nrd/nwr/A1:A0, start, ec, err).
- Accepts one configuration request over a valid/ready handshake, range-checks it, writes the four counter registers over the bus and issues a one-cycle start pulse.
- Waits for end-of-cycle (ec) or error from the counter, then reports completion status to the host.

Parameters:
- DW, 8, data width of bus and config fields.
- TIMEOUT, 1024, maximum WAIT_EC cycles before a timeout is declared (must be ≥1).
- TW, 11, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  host request valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  in  DW each  preload, upper limit, lower limit, cycle count.
- bus_dout  out  DW  write data toward counter Din.
- bus_oe  out  1  drive enable for bus_dout (tri-state control at top level).
- bus_din  in  DW  read data from counter Din; used only with the optional feature.
- ncs, nwr, nrd  out  1 each  active-low chip select, write, read.
- a1, a0  out  1 each  register address: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
- start  out  1  start pulse to counter.
- ctr_ec, ctr_err  in  1 each  counter end-cycle and error.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  3  0 OK, 1 RANGE, 2 CTR_ERR, 3 TIMEOUT, 4 READBACK; held until the next accept.

Behaviour:
- Reset values (applied at the next posedge while reset=1): ncs=nwr=nrd=1; a1=a0=0; bus_oe=0; bus_dout=0; start=0; busy=0; done=0; status=0; cfg_ready=1; state=IDLE; timeout counter=0. Reset mid-sequence aborts the sequence immediately; no done is produced.
- IDLE: when cfg_valid & cfg_ready, capture all four fields.
  - If plr<llr or plr>ulr: no bus activity; go to REPORT with status=RANGE.
  - Otherwise go to WR_PLR.
- WR_PLR → WR_ULR → WR_LLR → WR_CCR, one cycle each. In each: ncs=0, nwr=0, nrd=1, bus_oe=1, address per register, bus_dout=captured value. The counter samples at the end of the cycle.
- After WR_CCR: go to START if captured ccr≠0. If ccr==0, go to REPORT with status=OK and no start pulse.
- START, one cycle: start=1, ncs=0, nwr=1, bus_oe=0. Then WAIT_EC.
- WAIT_EC: ncs=0, bus idle. Timeout counter increments each cycle. Exit conditions, in priority order:
  - ctr_err=1 → status CTR_ERR.
  - ctr_ec=1 → status OK.
  - counter reaches TIMEOUT-1 → status TIMEOUT.
  - Any exit goes to REPORT.
- REPORT, one cycle: done=1, busy=0 on the following cycle; return to IDLE.
- Latency, accept to done:
  - Range fail: 2 cycles.
  - ccr==0: 6 cycles.
  - Normal: 6 + WAIT_EC length + 1.
- cfg_valid is ignored while busy; inputs are not re-sampled after capture.
- ncs deasserts in IDLE and REPORT.

Optional Feature:
- Macro COUNTER_CFG_READBACK_EN.
- Defined: after WR_CCR, insert RD_PLR, RD_ULR, RD_LLR, RD_CCR (one cycle each): ncs=0, nrd=0, nwr=1, bus_oe=0, address set. bus_din is sampled at the end of each cycle and compared with the captured value. Any mismatch goes to REPORT with status=READBACK and no start. Otherwise continue to the ccr≠0/ccr==0 decision. Normal latency grows by 4.
- Undefined: RD states absent, nrd held 1, bus_din unused, status 4 never produced.

Decomposition:
- Package counter_cfg_pkg holds:
  - state enum (IDLE, WR_PLR, WR_ULR, WR_LLR, WR_CCR, RD_PLR..RD_CCR, START, WAIT_EC, REPORT);
  - status code constants;
  - register address constants ADDR_PLR/ULR/LLR/CCR.
- One sub-module, cfg_timeout_timer (clear, enable, expired output; TW/TIMEOUT parameters). The FSM and bus drive remain in the top.

Test Plan:
- Reset for 2 cycles, then request plr=10, ulr=15, llr=5, ccr=2 → bus writes 10,15,5,2 at addresses 00,01,10,11 on consecutive cycles, one start pulse; inject ctr_ec after 40 cycles → done with status=0.
- Request plr=3, ulr=10, llr=5 → no ncs/nwr activity; done 2 cycles after accept with status=1.
- Request ccr=0 (plr=1, ulr=255, llr=0) → four writes, no start, done with status=0.
- Valid config with ctr_ec never asserted, TIMEOUT=16 → done with status=3 exactly 16 cycles after entering WAIT_EC; ctr_err asserted in the same cycle as ctr_ec → status=2.
- Assert reset during WR_LLR → next posedge all outputs at reset values, no done; a fresh request then completes normally. With COUNTER_CFG_READBACK_EN, return 6 instead of 5 on the LLR read → status=4 and no start.

Source files
------------

// File: rtl/counter_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : counter_cfg_pkg                                        |
// | Description : Shared states, status codes and register addresses    |
// |               for the counter configuration master.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package counter_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_PLR  = 4'd1,
        WR_ULR  = 4'd2,
        WR_LLR  = 4'd3,
        WR_CCR  = 4'd4,
        RD_PLR  = 4'd5,
        RD_ULR  = 4'd6,
        RD_LLR  = 4'd7,
        RD_CCR  = 4'd8,
        START   = 4'd9,
        WAIT_EC = 4'd10,
        REPORT  = 4'd11
    } state_t;

    localparam logic [2:0] STATUS_OK       = 3'd0;
    localparam logic [2:0] STATUS_RANGE    = 3'd1;
    localparam logic [2:0] STATUS_CTR_ERR  = 3'd2;
    localparam logic [2:0] STATUS_TIMEOUT  = 3'd3;
    localparam logic [2:0] STATUS_READBACK = 3'd4;

    localparam logic [1:0] ADDR_PLR = 2'b00;
    localparam logic [1:0] ADDR_ULR = 2'b01;
    localparam logic [1:0] ADDR_LLR = 2'b10;
    localparam logic [1:0] ADDR_CCR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cfg_timeout_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cfg_timeout_timer                                      |
// | Description : Cycle counter that flags expiry on its TIMEOUT-th      |
// |               enabled cycle after a clear.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cfg_timeout_timer #(
    parameter int TW      = 11,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // Saturates at the last value so a stalled enable can never wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/counter_cfg_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : counter_cfg_master                                     |
// | Description : Range-checks a host config, writes PLR/ULR/LLR/CCR     |
// |               over the counter bus, starts it and reports status.    |
// |               COUNTER_CFG_READBACK_EN adds a verify-by-read pass.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module counter_cfg_master
    import counter_cfg_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_plr,
    input  logic [DW-1:0] cfg_ulr,
    input  logic [DW-1:0] cfg_llr,
    input  logic [DW-1:0] cfg_ccr,
    output logic [DW-1:0] bus_dout,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_din,
    output logic          ncs,
    output logic          nwr,
    output logic          nrd,
    output logic          a1,
    output logic          a0,
    output logic          start,
    input  logic          ctr_ec,
    input  logic          ctr_err,
    output logic          busy,
    output logic          done,
    output logic [2:0]    status
);

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_plr, r_ulr, r_llr, r_ccr;
    logic [2:0]    r_status, w_status_next;
    logic          r_done;
    logic          w_capture;
    logic          w_ncs, w_nwr, w_nrd, w_oe, w_start, w_timer_en;
    logic [1:0]    w_addr;
    logic [DW-1:0] w_dout;
    logic          w_expired;

    cfg_timeout_timer #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state != WAIT_EC),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_status <= STATUS_OK;
            r_done   <= 1'b0;
            r_plr    <= '0;
            r_ulr    <= '0;
            r_llr    <= '0;
            r_ccr    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
            r_done   <= (r_state == REPORT);
            if (w_capture) begin
                r_plr <= cfg_plr;
                r_ulr <= cfg_ulr;
                r_llr <= cfg_llr;
                r_ccr <= cfg_ccr;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_capture     = 1'b0;
        w_ncs         = 1'b1;
        w_nwr         = 1'b1;
        w_nrd         = 1'b1;
        w_oe          = 1'b0;
        w_addr        = ADDR_PLR;
        w_dout        = '0;
        w_start       = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_capture = 1'b1;
                    if ((cfg_plr < cfg_llr) || (cfg_plr > cfg_ulr)) begin
                        w_state_next  = REPORT;
                        w_status_next = STATUS_RANGE;
                    end else begin
                        w_state_next  = WR_PLR;
                        w_status_next = STATUS_OK;
                    end
                end
            end
            WR_PLR: begin
                {w_ncs, w_nwr, w_oe} = 3'b001;
                w_addr = ADDR_PLR; w_dout = r_plr; w_state_next = WR_ULR;
            end
            WR_ULR: begin
                {w_ncs, w_nwr, w_oe} = 3'b001;
                w_addr = ADDR_ULR; w_dout = r_ulr; w_state_next = WR_LLR;
            end
            WR_LLR: begin
                {w_ncs, w_nwr, w_oe} = 3'b001;
                w_addr = ADDR_LLR; w_dout = r_llr; w_state_next = WR_CCR;
            end
            WR_CCR: begin
                {w_ncs, w_nwr, w_oe} = 3'b001;
                w_addr = ADDR_CCR; w_dout = r_ccr;
`ifdef COUNTER_CFG_READBACK_EN
                w_state_next = RD_PLR;
`else
                w_state_next = (r_ccr != '0) ? START : REPORT;
`endif
            end
`ifdef COUNTER_CFG_READBACK_EN
            // Any readback mismatch aborts at once, before the counter is started.
            RD_PLR: begin
                {w_ncs, w_nrd} = 2'b00; w_addr = ADDR_PLR;
                if (bus_din != r_plr) begin
                    w_state_next = REPORT; w_status_next = STATUS_READBACK;
                end else w_state_next = RD_ULR;
            end
            RD_ULR: begin
                {w_ncs, w_nrd} = 2'b00; w_addr = ADDR_ULR;
                if (bus_din != r_ulr) begin
                    w_state_next = REPORT; w_status_next = STATUS_READBACK;
                end else w_state_next = RD_LLR;
            end
            RD_LLR: begin
                {w_ncs, w_nrd} = 2'b00; w_addr = ADDR_LLR;
                if (bus_din != r_llr) begin
                    w_state_next = REPORT; w_status_next = STATUS_READBACK;
                end else w_state_next = RD_CCR;
            end
            RD_CCR: begin
                {w_ncs, w_nrd} = 2'b00; w_addr = ADDR_CCR;
                if (bus_din != r_ccr) begin
                    w_state_next = REPORT; w_status_next = STATUS_READBACK;
                end else w_state_next = (r_ccr != '0) ? START : REPORT;
            end
`endif
            START: begin
                w_ncs = 1'b0; w_start = 1'b1; w_state_next = WAIT_EC;
            end
            WAIT_EC: begin
                w_ncs = 1'b0; w_timer_en = 1'b1;
                if (ctr_err) begin
                    w_state_next = REPORT; w_status_next = STATUS_CTR_ERR;
                end else if (ctr_ec) begin
                    w_state_next = REPORT; w_status_next = STATUS_OK;
                end else if (w_expired) begin
                    w_state_next = REPORT; w_status_next = STATUS_TIMEOUT;
                end
            end
            REPORT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

`ifndef COUNTER_CFG_READBACK_EN
    logic w_unused;
    assign w_unused = ^bus_din;
`endif

    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign status    = r_status;
    assign ncs       = w_ncs;
    assign nwr       = w_nwr;
    assign nrd       = w_nrd;
    assign bus_oe    = w_oe;
    assign bus_dout  = w_dout;
    assign a1        = w_addr[1];
    assign a0        = w_addr[0];
    assign start     = w_start;

endmodule
`default_nettype wire

// File: tb/tb_counter_cfg_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_counter_cfg_master                                  |
// | Description : Scoreboard bench for counter_cfg_master (main DUT with |
// |               TIMEOUT=64, second instance with TIMEOUT=16).          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_counter_cfg_master;
    import counter_cfg_pkg::*;

`ifdef COUNTER_CFG_READBACK_EN
    localparam int RB = 4;
`else
    localparam int RB = 0;
`endif

    typedef struct packed {
        logic [15:0] k;
        logic        oe;
        logic [1:0]  a;
        logic [7:0]  d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_plr = '0, cfg_ulr = '0, cfg_llr = '0, cfg_ccr = '0;
    logic [7:0] bus_din;
    logic       ctr_ec = 1'b0, ctr_err = 1'b0;
    logic       corrupt = 1'b0;

    logic       cfg_ready, bus_oe, ncs, nwr, nrd, a1, a0, start, busy, done;
    logic [7:0] bus_dout;
    logic [2:0] status;
    logic       t_cfg_ready, t_bus_oe, t_ncs, t_nwr, t_nrd, t_a1, t_a0, t_start, t_busy, t_done;
    logic [7:0] t_bus_dout;
    logic [2:0] t_status;

    int   n_pass = 0, n_total = 0;
    wr_t  exp_q[$], act_q[$];
    int   start_cnt, start_k, done_k, t_done_k, rd_cnt, ncs_cnt;
    logic [2:0] done_st, t_done_st;
    logic [7:0] regs [4];

    always #5 clk = ~clk;

    counter_cfg_master #(.DW(8), .TIMEOUT(64), .TW(7)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
        .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
        .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0), .start(start),
        .ctr_ec(ctr_ec), .ctr_err(ctr_err), .busy(busy), .done(done), .status(status)
    );

    counter_cfg_master #(.DW(8), .TIMEOUT(16), .TW(5)) dut_t (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(t_cfg_ready),
        .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
        .bus_dout(t_bus_dout), .bus_oe(t_bus_oe), .bus_din(bus_din),
        .ncs(t_ncs), .nwr(t_nwr), .nrd(t_nrd), .a1(t_a1), .a0(t_a0), .start(t_start),
        .ctr_ec(ctr_ec), .ctr_err(ctr_err), .busy(t_busy), .done(t_done), .status(t_status)
    );

    // Counter register-file model; corrupt turns an LLR of 5 into 6 on readback.
    always_ff @(posedge clk) begin
        if (!ncs && !nwr) regs[{a1, a0}] <= bus_dout;
    end

    always_comb begin
        bus_din = 8'h00;
        if (!nrd) bus_din = regs[{a1, a0}] ^ ((corrupt && ({a1, a0} == ADDR_LLR)) ? 8'h03 : 8'h00);
    end

    function automatic void push_writes(input logic [7:0] p, input logic [7:0] u,
                                        input logic [7:0] l, input logic [7:0] c);
        exp_q.push_back('{16'd1, 1'b1, ADDR_PLR, p});
        exp_q.push_back('{16'd2, 1'b1, ADDR_ULR, u});
        exp_q.push_back('{16'd3, 1'b1, ADDR_LLR, l});
        exp_q.push_back('{16'd4, 1'b1, ADDR_CCR, c});
    endfunction

    task automatic set_req(input logic [7:0] p, input logic [7:0] u,
                           input logic [7:0] l, input logic [7:0] c);
        cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c;
        cfg_valid = 1'b1;
    endtask

    // Runs from the accept edge; k=1 is the first cycle after it.
    task automatic run_txn(input int ec_k, input bit with_err, input int max_k);
        act_q.delete();
        start_cnt = 0; start_k = -1; done_k = -1; t_done_k = -1; rd_cnt = 0; ncs_cnt = 0;
        done_st = 3'b111; t_done_st = 3'b111;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int k = 1; k <= max_k; k++) begin
            if (!ncs) ncs_cnt++;
            if (!ncs && !nwr) act_q.push_back('{k[15:0], bus_oe, {a1, a0}, bus_dout});
            if (!nrd) rd_cnt++;
            if (start) begin start_cnt++; start_k = k; end
            if (t_done && t_done_k < 0) begin t_done_k = k; t_done_st = t_status; end
            if (done) begin done_k = k; done_st = status; break; end
            ctr_ec  = (k == ec_k);
            ctr_err = with_err && (k == ec_k);
            @(posedge clk); #1;
        end
        ctr_ec = 1'b0; ctr_err = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({ncs, nwr, nrd, a1, a0, bus_oe, bus_dout, start, busy, done, status, cfg_ready, t_busy}
            !== {3'b111, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0})
            $display("FAIL reset_outputs: got ncs/nwr/nrd=%b%b%b a=%b%b oe=%b d=%h st=%b busy=%b done=%b status=%0d ready=%b, required 111 00 0 00 0 0 0 0 1",
                     ncs, nwr, nrd, a1, a0, bus_oe, bus_dout, start, busy, done, status, cfg_ready);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_normal;
        wr_t e, a;
        exp_q.delete(); push_writes(8'd10, 8'd15, 8'd5, 8'd2);
        set_req(8'd10, 8'd15, 8'd5, 8'd2);
        run_txn(45 + RB, 1'b0, 200);
        n_total++;
        if (act_q.size() != exp_q.size()) $display("FAIL normal_nwr: got %0d writes, required %0d", act_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL normal_wr: got k=%0d oe=%b a=%0d d=%0d, required k=%0d oe=%b a=%0d d=%0d", a.k, a.oe, a.a, a.d, e.k, e.oe, e.a, e.d);
            else n_pass++;
        end
        n_total++;
        if (start_cnt !== 1 || start_k !== 5 + RB) $display("FAIL normal_start: got %0d pulses at k=%0d, required 1 at k=%0d", start_cnt, start_k, 5 + RB);
        else n_pass++;
        n_total++;
        if (rd_cnt !== RB) $display("FAIL normal_reads: got %0d, required %0d", rd_cnt, RB);
        else n_pass++;
        n_total++;
        if (done_k !== 47 + RB || done_st !== STATUS_OK) $display("FAIL normal_done: got k=%0d status=%0d, required k=%0d status=0", done_k, done_st, 47 + RB);
        else n_pass++;
    endtask

    task automatic test_range;
        exp_q.delete();
        set_req(8'd3, 8'd10, 8'd5, 8'd4);
        run_txn(-1, 1'b0, 20);
        n_total++;
        if (ncs_cnt !== 0 || act_q.size() != 0 || start_cnt !== 0) $display("FAIL range_bus: got ncs_low=%0d writes=%0d starts=%0d, required 0 0 0", ncs_cnt, act_q.size(), start_cnt);
        else n_pass++;
        n_total++;
        if (done_k !== 2 || done_st !== STATUS_RANGE) $display("FAIL range_done: got k=%0d status=%0d, required k=2 status=1", done_k, done_st);
        else n_pass++;
    endtask

    task automatic test_ccr_zero;
        wr_t e, a;
        exp_q.delete(); push_writes(8'd1, 8'd255, 8'd0, 8'd0);
        set_req(8'd1, 8'd255, 8'd0, 8'd0);
        run_txn(-1, 1'b0, 30);
        n_total++;
        if (act_q.size() != exp_q.size()) $display("FAIL ccr0_nwr: got %0d writes, required %0d", act_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL ccr0_wr: got k=%0d a=%0d d=%0d, required k=%0d a=%0d d=%0d", a.k, a.a, a.d, e.k, e.a, e.d);
            else n_pass++;
        end
        n_total++;
        if (start_cnt !== 0 || done_k !== 6 + RB || done_st !== STATUS_OK) $display("FAIL ccr0_done: got starts=%0d k=%0d status=%0d, required 0 k=%0d status=0", start_cnt, done_k, done_st, 6 + RB);
        else n_pass++;
    endtask

    task automatic test_timeout;
        exp_q.delete();
        set_req(8'd5, 8'd9, 8'd1, 8'd3);
        run_txn(-1, 1'b0, 200);
        n_total++;
        if (t_done_k !== 23 + RB || t_done_st !== STATUS_TIMEOUT) $display("FAIL timeout16: got k=%0d status=%0d, required k=%0d status=3", t_done_k, t_done_st, 23 + RB);
        else n_pass++;
        n_total++;
        if (done_k !== 71 + RB || done_st !== STATUS_TIMEOUT) $display("FAIL timeout64: got k=%0d status=%0d, required k=%0d status=3", done_k, done_st, 71 + RB);
        else n_pass++;
    endtask

    task automatic test_err;
        set_req(8'd7, 8'd7, 8'd7, 8'd1);
        run_txn(8 + RB, 1'b1, 60);
        n_total++;
        if (start_cnt !== 1 || done_k !== 10 + RB || done_st !== STATUS_CTR_ERR) $display("FAIL err_prio: got starts=%0d k=%0d status=%0d, required 1 k=%0d status=2", start_cnt, done_k, done_st, 10 + RB);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        wr_t e, a;
        int dcnt;
        set_req(8'd10, 8'd20, 8'd5, 8'd7);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({ncs, nwr, a1, a0, busy} !== 5'b00101) $display("FAIL mid_wr_llr: got ncs=%b nwr=%b a=%b%b busy=%b, required 0 0 10 1", ncs, nwr, a1, a0, busy);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({ncs, nwr, nrd, a1, a0, bus_oe, bus_dout, start, busy, done, status, cfg_ready}
            !== {3'b111, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1})
            $display("FAIL mid_reset: got ncs/nwr/nrd=%b%b%b a=%b%b oe=%b d=%h busy=%b done=%b status=%0d", ncs, nwr, nrd, a1, a0, bus_oe, bus_dout, busy, done, status);
        else n_pass++;
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || t_done) dcnt++;
        end
        n_total++;
        if (dcnt !== 0) $display("FAIL mid_no_done: got %0d done pulses, required 0", dcnt);
        else n_pass++;
        exp_q.delete(); push_writes(8'd20, 8'd30, 8'd10, 8'd4);
        set_req(8'd20, 8'd30, 8'd10, 8'd4);
        run_txn(6 + RB, 1'b0, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_total++;
            if (act_q.size() == 0) begin
                $display("FAIL fresh_wr: got no write, required k=%0d a=%0d d=%0d", e.k, e.a, e.d);
                continue;
            end
            a = act_q.pop_front();
            if (a !== e) $display("FAIL fresh_wr: got k=%0d a=%0d d=%0d, required k=%0d a=%0d d=%0d", a.k, a.a, a.d, e.k, e.a, e.d);
            else n_pass++;
        end
        n_total++;
        if (done_k !== 8 + RB || done_st !== STATUS_OK) $display("FAIL fresh_done: got k=%0d status=%0d, required k=%0d status=0", done_k, done_st, 8 + RB);
        else n_pass++;
    endtask

`ifdef COUNTER_CFG_READBACK_EN
    task automatic test_readback;
        corrupt = 1'b1;
        set_req(8'd10, 8'd15, 8'd5, 8'd2);
        run_txn(-1, 1'b0, 60);
        corrupt = 1'b0;
        n_total++;
        if (act_q.size() != 4 || start_cnt !== 0 || done_k < 0 || done_st !== STATUS_READBACK)
            $display("FAIL readback: got writes=%0d starts=%0d k=%0d status=%0d, required 4 0 done status=4", act_q.size(), start_cnt, done_k, done_st);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_normal;
        test_range;
        test_ccr_zero;
        test_timeout;
        test_err;
        test_reset_mid;
`ifdef COUNTER_CFG_READBACK_EN
        test_readback;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
